// File: rtl/finv_seq_if.sv
// Handshake bundle between the issue stage and the sequential reciprocal unit.
// The operand side uses valid/ready. The result side uses valid/ready plus an exception flag.
interface finv_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        exception;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y, exception
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y, exception
    );
endinterface

// File: rtl/finv_seq.sv
// Sequential IEEE-754 binary32 reciprocal, y = 1/x.
// The significand a = 1.m is held in Q2.25 fixed point. The initial guess is 3/2 - a/2.
// One Newton-step datapath, x' = x*(2 - a*x), is reused for ITER cycles.
// Every 54-bit product is rounded half-even back to Q2.25.
module finv_seq #(
    parameter int ITER = 4
) (
    input  logic       clk,
    input  logic       rstn,
    finv_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_ITER,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam logic [26:0] Q_ONE        = 27'd1 << 25;
    localparam logic [26:0] Q_TWO        = 27'd1 << 26;
    localparam logic [26:0] Q_THREE_HALF = 27'd3 << 24;

    state_t             state;
    logic [2:0]         cnt;
    logic [31:0]        x_reg;
    logic signed [10:0] exp_eff;
    logic [26:0]        a_reg;
    logic [26:0]        xk;
    logic               out_valid_r;
    logic [31:0]        y_r;
    logic               exc_r;

    // Fields of the latched operand
    logic        sgn;
    logic [7:0]  e;
    logic [22:0] m;
    assign sgn = x_reg[31];
    assign e   = x_reg[30:23];
    assign m   = x_reg[22:0];

    logic is_nan, is_inf, is_zero;
    assign is_nan  = (e == 8'hFF) && (m != 23'd0);
    assign is_inf  = (e == 8'hFF) && (m == 23'd0);
    assign is_zero = (e == 8'd0)  && (m == 23'd0);

    // Locate the leading one of a denormal fraction so it can be moved to the hidden-bit position
    logic [4:0] lead;
    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (m[i]) lead = 5'(i);
        end
    end

    logic [4:0]         shift;
    logic [22:0]        mant_dec;
    logic signed [10:0] e_dec;
    logic [26:0]        a_dec;
    logic [26:0]        x0;

    assign shift    = 5'd23 - lead;
    assign mant_dec = (e == 8'd0) ? (m << shift) : m;
    assign e_dec    = (e == 8'd0) ? (11'sd1 - $signed({6'd0, shift})) : $signed({3'd0, e});
    assign a_dec    = {2'b01, mant_dec, 2'b00};
    assign x0       = Q_THREE_HALF - (a_dec >> 1);

    // Round a Q4.50 product back to Q2.25, half-even on the guard bit
    function automatic logic [26:0] round_q(input logic [53:0] p);
        logic up;
        up = p[24] & ((|p[23:0]) | p[25]);
        return 27'(p[53:25] + 29'(up));
    endfunction

    logic [53:0] prod_ax;
    logic [53:0] prod_xd;
    logic [26:0] ax;
    logic [26:0] dk;
    logic [26:0] x_next;

    assign prod_ax = 54'(a_reg) * 54'(xk);
    assign ax      = round_q(prod_ax);
    assign dk      = Q_TWO - ax;
    assign prod_xd = 54'(xk) * 54'(dk);
    assign x_next  = round_q(prod_xd);

    // Pack the converged reciprocal into binary32: normalize, round to 23 bits, then range-check the exponent
    logic signed [10:0] f;
    logic [22:0]        mant;
    logic               rnd_up;
    logic [23:0]        mant_r;
    logic [22:0]        mant_fin;
    logic [31:0]        res;
    logic               res_exc;
    always_comb begin
        f        = 11'sd0;
        mant     = 23'd0;
        rnd_up   = 1'b0;
        mant_fin = 23'd0;
        res      = 32'd0;
        res_exc  = 1'b0;
        if (a_reg == Q_ONE) begin
            f = 11'sd254 - exp_eff;
        end else if (xk[25]) begin
            f      = 11'sd254 - exp_eff;
            mant   = xk[24:2];
            rnd_up = xk[1] & (xk[0] | xk[2]);
        end else if (xk[24]) begin
            f      = 11'sd253 - exp_eff;
            mant   = xk[23:1];
            rnd_up = xk[0] & xk[1];
        end else begin
            f    = 11'sd252 - exp_eff;
            mant = xk[22:0];
        end
        mant_r = {1'b0, mant} + 24'(rnd_up);
        if (mant_r[23]) begin
            f        = f + 11'sd1;
            mant_fin = 23'd0;
        end else begin
            mant_fin = mant_r[22:0];
        end
        if (f >= 11'sd255) begin
            res     = {sgn, 8'hFF, 23'd0};
            res_exc = 1'b1;
        end else if (f <= 11'sd0) begin
            res     = {sgn, 31'd0};
            res_exc = 1'b0;
        end else begin
            res     = {sgn, f[7:0], mant_fin};
            res_exc = 1'b0;
        end
    end

    // Control FSM and all datapath registers; outputs are registered and change only on state transitions
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            cnt         <= 3'd0;
            x_reg       <= 32'd0;
            exp_eff     <= 11'sd0;
            a_reg       <= 27'd0;
            xk          <= 27'd0;
            out_valid_r <= 1'b0;
            y_r         <= 32'd0;
            exc_r       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        x_reg <= bus.x;
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (is_nan) begin
                        y_r         <= {sgn, 8'hFF, 1'b1, m[21:0]};
                        exc_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else if (is_inf) begin
                        y_r         <= {sgn, 31'd0};
                        exc_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else if (is_zero) begin
                        y_r         <= {sgn, 8'hFF, 23'd0};
                        exc_r       <= 1'b1;
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        a_reg   <= a_dec;
                        xk      <= x0;
                        exp_eff <= e_dec;
                        cnt     <= 3'(ITER);
                        state   <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    xk  <= x_next;
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= ST_ROUND;
                end
                ST_ROUND: begin
                    y_r         <= res;
                    exc_r       <= res_exc;
                    out_valid_r <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;
    assign bus.exception = exc_r;

endmodule

// File: tb/tb_finv_seq.sv
// Self-checking bench for finv_seq. Two instances, ITER=4 and ITER=3, receive identical stimulus.
// Expected results come from a real-arithmetic reciprocal that is rounded to binary32.
module tb_finv_seq;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    finv_seq_if bus4();
    finv_seq_if bus3();

    finv_seq #(.ITER(4)) dut4 (.clk(clk), .rstn(rstn), .bus(bus4));
    finv_seq #(.ITER(3)) dut3 (.clk(clk), .rstn(rstn), .bus(bus3));

    int tests_run    = 0;
    int tests_failed = 0;

    // Compare one observed value with its expected value, allowing a distance of tol (used for 1-ulp checks)
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected, input int tol);
        longint diff;
        tests_run++;
        diff = longint'({32'd0, observed}) - longint'({32'd0, expected});
        if (diff < 0) diff = -diff;
        if (diff > longint'(tol)) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, want %h (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    // Reference 1/x: decode binary32, divide in double precision, round half-even to binary32,
    // then apply the unit's overflow and flush-to-zero rules. Returns {exception, y}.
    function automatic logic [32:0] refModel(input logic [31:0] xin);
        logic        s;
        int          ex;
        int          k;
        int          fe;
        logic [22:0] mf;
        logic [22:0] mant;
        logic [23:0] mr;
        logic        up;
        real         v;
        real         r;
        logic [63:0] rb;
        s  = xin[31];
        ex = int'(xin[30:23]);
        mf = xin[22:0];
        if (ex == 255) return (mf != 23'd0) ? {1'b0, s, 8'hFF, 1'b1, mf[21:0]} : {1'b0, s, 31'd0};
        if (ex == 0 && mf == 23'd0) return {1'b1, s, 8'hFF, 23'd0};
        v = (ex != 0) ? 8388608.0 : 0.0;
        v = v + real'(mf);
        k = ((ex == 0) ? 1 : ex) - 150;
        for (int i = 0; i < k; i++) v = v * 2.0;
        for (int i = 0; i < -k; i++) v = v * 0.5;
        r    = 1.0 / v;
        rb   = $realtobits(r);
        fe   = int'(rb[62:52]) - 1023 + 127;
        mant = rb[51:29];
        up   = rb[28] & ((|rb[27:0]) | rb[29]);
        mr   = {1'b0, mant} + 24'(up);
        if (mr[23]) begin
            fe   = fe + 1;
            mant = 23'd0;
        end else begin
            mant = mr[22:0];
        end
        if (fe >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (fe <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(fe), mant};
    endfunction

    // Offer one operand to both units with out_ready high, and record each result and its latency
    // in cycles after the accept edge. Starts and ends on a negedge with both units idle.
    task automatic applyStimulus(input logic [31:0] xin,
                                 output logic [31:0] y4, output logic e4, output int lat4,
                                 output logic [31:0] y3, output logic e3, output int lat3);
        y4 = 32'd0; e4 = 1'b0; lat4 = -1;
        y3 = 32'd0; e3 = 1'b0; lat3 = -1;
        bus4.x = xin; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        bus3.x = xin; bus3.in_valid = 1'b1; bus3.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0; bus4.x = $urandom;
        bus3.in_valid = 1'b0; bus3.x = $urandom;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (lat4 < 0 && bus4.out_valid) begin
                y4 = bus4.y; e4 = bus4.exception; lat4 = c;
            end
            if (lat3 < 0 && bus3.out_valid) begin
                y3 = bus3.y; e3 = bus3.exception; lat3 = c;
            end
            if (lat4 >= 0 && lat3 >= 0) break;
        end
        @(negedge clk);
    endtask

    // Directed operand with a known answer on both instances
    task automatic runDirected(input string tag, input logic [31:0] xin, input logic [31:0] y_exp,
                               input logic e_exp, input logic special, input int tol);
        logic [31:0] y4, y3;
        logic        e4, e3;
        int          lat4, lat3;
        applyStimulus(xin, y4, e4, lat4, y3, e3, lat3);
        checkOutput({tag, "_y4"},   y4, y_exp, tol);
        checkOutput({tag, "_exc4"}, 32'(e4), 32'(e_exp), 0);
        checkOutput({tag, "_lat4"}, 32'(lat4), special ? 32'd2 : 32'd7, 0);
        checkOutput({tag, "_y3"},   y3, y_exp, tol);
        checkOutput({tag, "_exc3"}, 32'(e3), 32'(e_exp), 0);
        checkOutput({tag, "_lat3"}, 32'(lat3), special ? 32'd2 : 32'd6, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] xr;
        logic [32:0] ref_val;
        logic [31:0] y4, y3;
        logic        e4, e3;
        int          lat4, lat3;
        int          seen;
        int          t1, t2;
        logic        prev;

        rstn = 1'b0;
        bus4.in_valid = 1'b0; bus4.x = 32'd0; bus4.out_ready = 1'b1;
        bus3.in_valid = 1'b0; bus3.x = 32'd0; bus3.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("rst_out_valid", 32'(bus4.out_valid), 32'd0, 0);
        checkOutput("rst_y",         bus4.y,              32'd0, 0);
        checkOutput("rst_exc",       32'(bus4.exception), 32'd0, 0);
        checkOutput("rst_in_ready",  32'(bus4.in_ready),  32'd1, 0);
        checkOutput("rst_in_ready3", 32'(bus3.in_ready),  32'd1, 0);
        rstn = 1'b1;
        @(negedge clk);

        runDirected("two",        32'h40000000, 32'h3F000000, 1'b0, 1'b0, 0);
        runDirected("one",        32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 0);
        runDirected("three",      32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 1);
        runDirected("neg_zero",   32'h80000000, 32'hFF800000, 1'b1, 1'b1, 0);
        runDirected("pos_inf",    32'h7F800000, 32'h00000000, 1'b0, 1'b1, 0);
        runDirected("nan",        32'hFFC00001, 32'hFFC00001, 1'b0, 1'b1, 0);
        runDirected("denorm_min", 32'h00000001, 32'h7F800000, 1'b1, 1'b0, 0);
        runDirected("denorm_127", 32'h00400000, 32'h7F000000, 1'b0, 1'b0, 0);
        runDirected("max_norm",   32'h7F7FFFFF, 32'h00000000, 1'b0, 1'b0, 0);
        runDirected("neg_quarter",32'hBE800000, 32'hC0800000, 1'b0, 1'b0, 0);

        // Throughput: operand held valid, consumer always ready
        bus4.x = 32'h40000000; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        prev = 1'b0; t1 = -1; t2 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus4.out_valid && !prev) begin
                if (t1 < 0) t1 = c;
                else begin
                    t2 = c;
                    break;
                end
            end
            prev = bus4.out_valid;
        end
        bus4.in_valid = 1'b0;
        checkOutput("thru_gap", (t2 >= 0) ? 32'(t2 - t1) : 32'hFFFFFFFF, 32'd8, 0);
        @(negedge clk);

        // Backpressure: first result 1/4 held for five cycles while a second operand 3.0 waits
        bus4.x = 32'h40800000; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus4.x = 32'h40400000;
        seen = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus4.out_valid) begin
                seen = 1;
                break;
            end
        end
        checkOutput("bp_valid", 32'(seen), 32'd1, 0);
        checkOutput("bp_y",     bus4.y, 32'h3E800000, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(bus4.out_valid), 32'd1, 0);
            checkOutput("bp_hold_y",     bus4.y, 32'h3E800000, 0);
            checkOutput("bp_hold_ready", 32'(bus4.in_ready), 32'd0, 0);
        end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_idle_ready", 32'(bus4.in_ready),  32'd1, 0);
        checkOutput("bp_idle_valid", 32'(bus4.out_valid), 32'd0, 0);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        lat4 = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus4.out_valid) begin
                lat4 = c;
                break;
            end
        end
        checkOutput("bp_second_lat", 32'(lat4), 32'd7, 0);
        checkOutput("bp_second_y",   bus4.y, 32'h3EAAAAAB, 1);
        @(negedge clk);

        // Reset in the middle of an operation
        bus4.x = 32'h40000000; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_ready",  32'(bus4.in_ready),  32'd1, 0);
        checkOutput("midrst_out_valid", 32'(bus4.out_valid), 32'd0, 0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput("postrst_in_ready", 32'(bus4.in_ready), 32'd1, 0);
            if (bus4.out_valid) seen = 1;
        end
        checkOutput("postrst_no_result", 32'(seen), 32'd0, 0);
        runDirected("after_rst", 32'h40000000, 32'h3F000000, 1'b0, 1'b0, 0);

        // Random normal operands against the reference model, both iteration counts
        for (int n = 0; n < 40; n++) begin
            xr = {1'($urandom_range(0, 1)), 8'($urandom_range(3, 250)), 23'($urandom)};
            if (n % 8 == 0) xr[22:0] = 23'd0;
            ref_val = refModel(xr);
            applyStimulus(xr, y4, e4, lat4, y3, e3, lat3);
            checkOutput("rand_y4",   y4, ref_val[31:0], 1);
            checkOutput("rand_exc4", 32'(e4), 32'(ref_val[32]), 0);
            checkOutput("rand_lat4", 32'(lat4), 32'd7, 0);
            checkOutput("rand_y3",   y3, ref_val[31:0], 1);
            checkOutput("rand_exc3", 32'(e3), 32'(ref_val[32]), 0);
            checkOutput("rand_lat3", 32'(lat3), 32'd6, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
